// File: rtl/counter_cmd_arbiter.sv
// Shared up/down counter behind a round-robin command arbiter.
// One requester is served per two cycles: IDLE arbitrates and latches, EXEC applies.
module counter_cmd_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [2*N-1:0]       cmd,
  input  logic [WIDTH*N-1:0]   data,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         ack,
  output logic [WIDTH-1:0]     count,
  output logic                 wrap,
  output logic                 busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] CMD_READ = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;
  localparam logic [1:0] CMD_LOAD = 2'b11;

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [PW-1:0]     win_q, win_n;
  logic [1:0]        cmd_q, cmd_n;
  logic [WIDTH-1:0]  data_q, data_n;
  logic [WIDTH-1:0]  count_n;
  logic [N-1:0]      grant_n, ack_n;
  logic              wrap_n;

  logic              found;
  logic [PW-1:0]     pick;
  int                idx_sum;

  // Round-robin search: first requester at or above ptr, wrapping modulo N.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    idx_sum = 0;
    for (int k = 0; k < N; k++) begin
      idx_sum = int'(ptr) + k;
      if (idx_sum >= N) idx_sum = idx_sum - N;
      if (!found && req[idx_sum[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win_q;
    cmd_n   = cmd_q;
    data_n  = data_q;
    count_n = count;
    grant_n = grant;
    ack_n   = '0;
    wrap_n  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n = '0;
          for (int i = 0; i < N; i++) begin
            if (pick == PW'(i)) begin
              grant_n[i] = 1'b1;
              cmd_n      = cmd[2*i +: 2];
              data_n     = data[WIDTH*i +: WIDTH];
            end
          end
          win_n   = pick;
          state_n = EXEC;
        end
      end
      EXEC: begin
        case (cmd_q)
          CMD_INC: begin
            count_n = count + 1'b1;
            wrap_n  = &count;
          end
          CMD_DEC: begin
            count_n = count - 1'b1;
            wrap_n  = ~|count;
          end
          CMD_LOAD: count_n = data_q;
          CMD_READ: count_n = count;
          default:  count_n = count;
        endcase
        ack_n   = grant;
        grant_n = '0;
        ptr_n   = (win_q == PW'(N-1)) ? '0 : win_q + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Reset aborts any command in flight, so no ack or wrap survives it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      win_q  <= '0;
      cmd_q  <= CMD_READ;
      data_q <= '0;
      count  <= '0;
      grant  <= '0;
      ack    <= '0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      win_q  <= win_n;
      cmd_q  <= cmd_n;
      data_q <= data_n;
      count  <= count_n;
      grant  <= grant_n;
      ack    <= ack_n;
      wrap   <= wrap_n;
    end
  end

  assign busy = (state == EXEC);

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Bench for counter_cmd_arbiter: directed scenarios then random traffic, all
// compared against a transaction-level model of arbitration and counter arithmetic.
module tb_counter_cmd_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int DW    = WIDTH * N;
  localparam int MOD   = 1 << WIDTH;

  localparam logic [1:0] RD  = 2'b00;
  localparam logic [1:0] INC = 2'b01;
  localparam logic [1:0] DEC = 2'b10;
  localparam logic [1:0] LD  = 2'b11;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req;
  logic [2*N-1:0]   cmd;
  logic [DW-1:0]    data;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int free_at = 0;
  int m_count = 0;
  int m_ptr = 0;
  int cur_count = 0;

  // Expectations scheduled a few cycles ahead, indexed by cycle modulo 4.
  logic [N-1:0] s_grant [4];
  logic [N-1:0] s_ack   [4];
  logic         s_wrap  [4];
  logic         s_cnt_v [4];
  int           s_cnt   [4];
  logic [N-1:0] model_ack;

  counter_cmd_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .cmd   (cmd),
    .data  (data),
    .grant (grant),
    .ack   (ack),
    .count (count),
    .wrap  (wrap),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
  endtask

  task automatic clear_slot(input int s);
    s_grant[s] = '0;
    s_ack[s]   = '0;
    s_wrap[s]  = 1'b0;
    s_cnt_v[s] = 1'b0;
    s_cnt[s]   = 0;
  endtask

  task automatic check_output();
    int s;
    s = cyc % 4;
    if (s_cnt_v[s]) cur_count = s_cnt[s];
    model_ack = s_ack[s];
    check("grant", 32'(grant), 32'(s_grant[s]));
    check("ack",   32'(ack),   32'(s_ack[s]));
    check("wrap",  32'(wrap),  32'(s_wrap[s]));
    check("busy",  32'(busy),  32'(s_grant[s] != '0));
    check("count", 32'(count), cur_count);
    clear_slot(s);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_output();
  endtask

  // Drives this cycle's inputs and lets the model react to them as a whole transaction.
  task automatic apply_stimulus(input logic rst, input logic [N-1:0] rq,
                                input logic [2*N-1:0] cm, input logic [DW-1:0] dt);
    int w, nv, d, idx;
    logic [1:0] c;
    logic wr;
    reset = rst;
    req   = rq;
    cmd   = cm;
    data  = dt;
    if (rst) begin
      for (int s = 0; s < 4; s++) clear_slot(s);
      s_cnt_v[(cyc+1)%4] = 1'b1;
      s_cnt[(cyc+1)%4]   = 0;
      m_count = 0;
      m_ptr   = 0;
      free_at = cyc + 1;
    end else if (cyc >= free_at && rq != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && rq[idx]) w = idx;
      end
      c  = cm[2*w +: 2];
      d  = int'(dt[WIDTH*w +: WIDTH]);
      nv = m_count;
      wr = 1'b0;
      case (c)
        INC: begin nv = (m_count + 1) % MOD;       wr = (m_count == MOD - 1); end
        DEC: begin nv = (m_count + MOD - 1) % MOD; wr = (m_count == 0);       end
        LD:  nv = d;
        default: nv = m_count;
      endcase
      s_grant[(cyc+1)%4] = N'(1) << w;
      s_ack[(cyc+2)%4]   = N'(1) << w;
      s_wrap[(cyc+2)%4]  = wr;
      s_cnt_v[(cyc+2)%4] = 1'b1;
      s_cnt[(cyc+2)%4]   = nv;
      m_count = nv;
      m_ptr   = (w + 1) % N;
      free_at = cyc + 2;
    end
  endtask

  function automatic logic [2*N-1:0] cmd_at(input int who, input logic [1:0] c);
    logic [2*N-1:0] r;
    r = '0;
    r[2*who +: 2] = c;
    return r;
  endfunction

  function automatic logic [DW-1:0] data_at(input int who, input logic [WIDTH-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    r[WIDTH*who +: WIDTH] = d;
    return r;
  endfunction

  task automatic wait_ack(input int who, input logic [N-1:0] rq,
                          input logic [2*N-1:0] cm, input logic [DW-1:0] dt);
    for (int n = 0; n < 16; n++) begin
      tick();
      if (model_ack[who]) return;
      apply_stimulus(1'b0, rq, cm, dt);
    end
    checks++;
    $error("[TB] FAIL wait_ack requester %0d: observed no ack within 16 cycles, required ack", who);
  endtask

  // One complete operation from a lone requester that drops req on its ack.
  task automatic do_op(input int who, input logic [1:0] c, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] exp_count, input logic exp_wrap);
    logic [N-1:0] rq;
    rq = N'(1) << who;
    tick();
    apply_stimulus(1'b0, rq, cmd_at(who, c), data_at(who, d));
    wait_ack(who, rq, cmd_at(who, c), data_at(who, d));
    check("op_ack",   32'(ack),   32'(rq));
    check("op_count", 32'(count), 32'(exp_count));
    check("op_wrap",  32'(wrap),  32'(exp_wrap));
    apply_stimulus(1'b0, '0, '0, '0);
  endtask

  initial begin
    int order[$];
    int acks, first0, gap0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] pend;

    for (int s = 0; s < 4; s++) clear_slot(s);
    model_ack = '0;
    reset = 1'b1;
    req   = '0;
    cmd   = '0;
    data  = '0;
    repeat (2) @(negedge clk);
    check_output();
    apply_stimulus(1'b0, '0, '0, '0);

    $display("[TB] single requester increments");
    do_op(0, INC, 8'h00, 8'h01, 1'b0);
    do_op(0, INC, 8'h00, 8'h02, 1'b0);
    do_op(0, INC, 8'h00, 8'h03, 1'b0);

    $display("[TB] four requesters hold inc");
    tick();
    apply_stimulus(1'b1, '0, '0, '0);
    tick();
    apply_stimulus(1'b0, '1, {N{INC}}, '0);
    acks = 0; first0 = -1; gap0 = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          order.push_back(i);
          if (i == 0) begin
            if (first0 < 0) first0 = cyc;
            else if (gap0 < 0) gap0 = cyc - first0;
          end
        end
      end
      if (model_ack != '0) begin
        acks++;
        if (acks == 4) check("s2_count_after_4", 32'(count), 32'd4);
      end
      apply_stimulus(1'b0, '1, {N{INC}}, '0);
    end
    check("s2_num_grants", 32'(order.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++)
      check("s2_order", (k < order.size()) ? order[k] : -1, exp_order[k]);
    check("s2_gap0", gap0, 32'd8);
    for (int t = 0; t < 3; t++) begin
      tick();
      apply_stimulus(1'b0, '0, '0, '0);
    end

    $display("[TB] wrap on inc and dec");
    do_op(2, LD,  8'hFF, 8'hFF, 1'b0);
    do_op(2, INC, 8'h00, 8'h00, 1'b1);
    do_op(2, DEC, 8'h00, 8'hFF, 1'b1);

    $display("[TB] command change after grant is ignored");
    tick();
    apply_stimulus(1'b0, 4'b0010, cmd_at(1, LD), data_at(1, 8'h5A));
    tick();
    apply_stimulus(1'b0, 4'b0010, cmd_at(1, DEC), data_at(1, 8'h11));
    wait_ack(1, 4'b0010, cmd_at(1, DEC), data_at(1, 8'h11));
    check("s4_ack",   32'(ack),   32'h2);
    check("s4_count", 32'(count), 32'h5A);
    apply_stimulus(1'b0, '0, '0, '0);

    $display("[TB] reset during exec");
    do_op(2, LD, 8'h10, 8'h10, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'b0010, cmd_at(1, INC), '0);
    tick();
    check("s5_busy", 32'(busy), 32'd1);
    apply_stimulus(1'b1, '0, '0, '0);
    tick();
    check("s5_count", 32'(count), 32'd0);
    check("s5_ack",   32'(ack),   32'd0);
    apply_stimulus(1'b0, '0, '0, '0);
    do_op(3, INC, 8'h00, 8'h01, 1'b0);

    $display("[TB] read command");
    do_op(0, LD, 8'h33, 8'h33, 1'b0);
    do_op(1, RD, 8'hC7, 8'h33, 1'b0);

    $display("[TB] random traffic");
    pend = '0;
    for (int t = 0; t < 400; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (model_ack[i]) pend[i] = ($urandom_range(0, 3) == 0);
        else if (!pend[i]) pend[i] = ($urandom_range(0, 2) == 0);
      end
      apply_stimulus($urandom_range(0, 60) == 0, pend, (2*N)'($urandom), DW'($urandom));
    end
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
